// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - size encodings, FSM states and lane helpers shared by the LSU.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_R = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STORE_W,
    RMW_RD,
    RMW_WR,
    RESP
  } state_e;

  localparam logic [31:0] LANE_B_MASK = 32'h0000_00ff;
  localparam logic [31:0] LANE_H_MASK = 32'h0000_ffff;

  // Bit offset of the addressed lane; halves ignore addr[0] so an odd half is forced aligned.
  function automatic logic [4:0] lane_shift(input logic [1:0] size, input logic [1:0] lo);
    return (size == SZ_B) ? {lo, 3'b000} : {lo[1], 4'b0000};
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational lane extract/extend for loads and lane merge for sub-word stores.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [15:0] wdata,
  output logic [31:0] ld_data,
  output logic [31:0] merged
);

  logic [4:0]  sh;
  logic [15:0] lane;
  logic [31:0] mask;

  always_comb begin
    sh   = lane_shift(size, addr_lo);
    lane = 16'(rdata >> sh);
    mask = (size == SZ_B) ? LANE_B_MASK : LANE_H_MASK;
    case (size)
      SZ_B:    ld_data = is_unsigned ? {24'h0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
      SZ_H:    ld_data = is_unsigned ? {16'h0, lane} : {{16{lane[15]}}, lane};
      default: ld_data = rdata;
    endcase
    merged = (rdata & ~(mask << sh)) | (({16'h0, wdata} & mask) << sh);
  end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store unit FSM: single-word memory access with byte/half read-modify-write.
// Define LSU_MISALIGN_CHECK_EN to reject misaligned half/word accesses instead of forcing alignment.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 101,
  parameter int MEM_AW    = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata
);

  state_e            state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic              mem_we_q, mem_we_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [31:0]       wdata_q, wdata_d;

  logic [31:0] req_idx;
  logic        req_err;
  logic [31:0] ld_data;
  logic [31:0] merged;

  assign req_idx = {2'b00, req_addr[31:2]};

  always_comb begin
    req_err = (req_size == SZ_R) || (req_idx >= 32'(MEM_WORDS));
`ifdef LSU_MISALIGN_CHECK_EN
    req_err = req_err || ((req_size == SZ_H) && req_addr[0])
                      || ((req_size == SZ_W) && (req_addr[1:0] != 2'b00));
`endif
  end

  lsu_align u_align (
    .rdata       (mem_rdata),
    .addr_lo     (addr_lo_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .wdata       (wdata_q[15:0]),
    .ld_data     (ld_data),
    .merged      (merged)
  );

  always_comb begin
    state_d      = state_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    addr_lo_d    = addr_lo_q;
    size_d       = size_q;
    uns_d        = uns_q;
    wdata_d      = wdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          req_ready_d  = 1'b0;
          addr_lo_d    = req_addr[1:0];
          size_d       = req_size;
          uns_d        = req_unsigned;
          wdata_d      = req_wdata;
          mem_addr_d   = MEM_AW'(req_idx);
          resp_rdata_d = 32'h0;
          if (req_err) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (!req_we) begin
            state_d = LOAD;
          end else if (req_size == SZ_W) begin
            state_d     = STORE_W;
            mem_we_d    = 1'b1;
            mem_wdata_d = req_wdata;
          end else begin
            state_d = RMW_RD;
          end
        end
      end
      LOAD: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = ld_data;
      end
      STORE_W, RMW_WR: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
      end
      RMW_RD: begin
        state_d     = RMW_WR;
        mem_we_d    = 1'b1;
        mem_wdata_d = merged;
      end
      RESP: begin
        if (resp_ready) begin
          state_d      = IDLE;
          req_ready_d  = 1'b1;
          resp_valid_d = 1'b0;
          resp_err_d   = 1'b0;
          resp_rdata_d = 32'h0;
        end
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 32'h0;
      addr_lo_q    <= 2'b00;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      wdata_q      <= 32'h0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      addr_lo_q    <= addr_lo_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      wdata_q      <= wdata_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - scoreboard bench for lsu_ctrl against a 101-word behavioural memory.
module tb_lsu_ctrl;

`ifdef LSU_MISALIGN_CHECK_EN
  localparam bit MISALIGN = 1'b1;
`else
  localparam bit MISALIGN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:100];
  logic [31:0] ref_mem [0:100];
  int          we_cnt = 0;
  logic [31:0] last_we_addr = 32'h0;
  int          n_checks = 0;
  int          n_pass = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nw;
  } exp_t;
  exp_t sb[$];

  lsu_ctrl #(.MEM_WORDS(101), .MEM_AW(32)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .mem_rdata    (mem_rdata)
  );

  always #5 CLK = ~CLK;

  assign mem_rdata = (mem_addr < 32'd101) ? mem[mem_addr[6:0]] : 32'h0;

  // mem_we/mem_addr/mem_wdata are registered and stable for the whole cycle, so commit mid-cycle.
  always @(negedge CLK) begin
    if (mem_we) begin
      if (mem_addr < 32'd101) mem[mem_addr[6:0]] = mem_wdata;
      we_cnt       = we_cnt + 1;
      last_we_addr = mem_addr;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic model(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, output exp_t e);
    int idx;
    int lo;
    logic [31:0] w;
    logic mis;
    idx = int'(addr[31:2]);
    lo  = int'(addr[1:0]);
    mis = (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00);
    e.rdata = 32'h0;
    e.nw    = 0;
    e.err   = (size == 2'd3) || (idx >= 101) || (MISALIGN && mis);
    if (size == 2'd1) lo = lo & 2;
    if (size == 2'd2) lo = 0;
    if (e.err) begin
      e.lat = 1;
    end else if (!we) begin
      e.lat = 2;
      w = ref_mem[idx];
      case (size)
        2'd0:    e.rdata = uns ? {24'h0, w[8*lo +: 8]} : {{24{w[8*lo+7]}}, w[8*lo +: 8]};
        2'd1:    e.rdata = uns ? {16'h0, w[8*lo +: 16]} : {{16{w[8*lo+15]}}, w[8*lo +: 16]};
        default: e.rdata = w;
      endcase
    end else begin
      e.nw = 1;
      if (size == 2'd2) begin
        ref_mem[idx] = wdata;
        e.lat = 2;
      end else begin
        w = ref_mem[idx];
        if (size == 2'd0) w[8*lo +: 8] = wdata[7:0];
        else              w[8*lo +: 16] = wdata[15:0];
        ref_mem[idx] = w;
        e.lat = 3;
      end
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input int hold);
    exp_t e;
    int lat;
    int w0;
    logic [31:0] idx;
    idx = {2'b00, addr[31:2]};
    model(we, size, uns, addr, wdata, e);
    sb.push_back(e);
    @(negedge CLK);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    resp_ready   = (hold == 0);
    check("req_ready_idle", {31'h0, req_ready}, 32'h1);
    w0 = we_cnt;
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge CLK);
      #1;
      lat++;
    end
    e = sb.pop_front();
    check("resp_valid", {31'h0, resp_valid}, 32'h1);
    check("latency", 32'(lat), 32'(e.lat));
    check("resp_rdata", resp_rdata, e.rdata);
    check("resp_err", {31'h0, resp_err}, {31'h0, e.err});
    repeat (hold) begin
      @(posedge CLK);
      #1;
      check("hold_valid", {31'h0, resp_valid}, 32'h1);
      check("hold_err", {31'h0, resp_err}, {31'h0, e.err});
      check("hold_rdata", resp_rdata, e.rdata);
      check("hold_req_ready", {31'h0, req_ready}, 32'h0);
    end
    resp_ready = 1'b1;
    @(posedge CLK);
    #1;
    check("resp_done", {31'h0, resp_valid}, 32'h0);
    check("req_ready_back", {31'h0, req_ready}, 32'h1);
    check("we_count", 32'(we_cnt - w0), 32'(e.nw));
    if (e.nw > 0) begin
      check("we_addr", last_we_addr, idx);
      check("mem_word", mem[idx[6:0]], ref_mem[idx[6:0]]);
    end
  endtask

  initial begin
    int w0;
    for (int i = 0; i < 101; i++) begin
      mem[i]     = (32'(i) * 32'h0101_0101) ^ 32'h5a5a_0000;
      ref_mem[i] = mem[i];
    end
    mem[4]   = 32'h1122_3344; ref_mem[4]   = mem[4];
    mem[5]   = 32'h8899_aabb; ref_mem[5]   = mem[5];
    mem[100] = 32'hcafe_f00d; ref_mem[100] = mem[100];

    repeat (2) @(posedge CLK);
    #1;
    check("rst_req_ready", {31'h0, req_ready}, 32'h1);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_resp_err", {31'h0, resp_err}, 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_mem_we", {31'h0, mem_we}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    @(negedge CLK);
    RST = 1'b1;

    do_req(1'b0, 2'd0, 1'b0, 32'h15, 32'h0, 0);
    do_req(1'b0, 2'd0, 1'b1, 32'h15, 32'h0, 0);
    do_req(1'b0, 2'd1, 1'b0, 32'h16, 32'h0, 0);
    do_req(1'b0, 2'd1, 1'b1, 32'h14, 32'h0, 0);
    do_req(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 0);
    do_req(1'b1, 2'd1, 1'b0, 32'h16, 32'h0000_1234, 0);
    check("half_store_word5", mem[5], 32'h1234_aabb);
    do_req(1'b1, 2'd0, 1'b0, 32'h11, 32'hffff_ff5a, 0);
    check("byte_store_word4", mem[4], 32'h1122_5a44);
    do_req(1'b1, 2'd2, 1'b0, 32'h13, 32'hdead_beef, 0);
    do_req(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 0);
    do_req(1'b0, 2'd2, 1'b0, 32'h194, 32'h0, 3);
    do_req(1'b0, 2'd2, 1'b0, 32'h190, 32'h0, 0);
    do_req(1'b0, 2'd1, 1'b0, 32'h17, 32'h0, 0);
    do_req(1'b1, 2'd0, 1'b0, 32'h203, 32'h0000_0011, 0);

    // Abandon a sub-word store while it is in RMW_RD.
    @(negedge CLK);
    req_valid    = 1'b1;
    req_we       = 1'b1;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_addr     = 32'h15;
    req_wdata    = 32'h0000_0077;
    resp_ready   = 1'b1;
    w0 = we_cnt;
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
    #2;
    RST = 1'b0;
    #1;
    check("rmw_rst_req_ready", {31'h0, req_ready}, 32'h1);
    check("rmw_rst_mem_we", {31'h0, mem_we}, 32'h0);
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("rmw_rst_we_count", 32'(we_cnt - w0), 32'h0);
    check("rmw_rst_word5", mem[5], ref_mem[5]);
    check("rmw_rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rmw_rst_req_ready_after", {31'h0, req_ready}, 32'h1);

    do_req(1'b0, 2'd0, 1'b0, 32'h15, 32'h0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 101, meaning the number of 32-bit words in the attached data memory.
REQ-002 SHALL have parameter MEM_AW, default 32, meaning the width of mem_addr.
REQ-003 SHALL have port CLK, input, 1, the clock.
REQ-004 SHALL have port RST, input, 1, the reset: asynchronous, active-low.
REQ-005 SHALL have port req_valid, input, 1, core request valid.
REQ-006 SHALL have port req_ready, output, 1, request accepted when high with req_valid.
REQ-007 SHALL have port req_we, input, 1, 1=store, 0=load.
REQ-008 SHALL have port req_size, input, 2, 00=byte, 01=half, 10=word, 11=reserved.
REQ-009 SHALL have port req_unsigned, input, 1, zero-extend loads when 1.
REQ-010 SHALL have port req_addr, input, 32, byte address.
REQ-011 SHALL have port req_wdata, input, 32, store data, right-justified.
REQ-012 SHALL have port resp_valid, output, 1, response valid.
REQ-013 SHALL have port resp_ready, input, 1, core accepts the response.
REQ-014 SHALL have port resp_rdata, output, 32, extended load data, 0 for stores and errors.
REQ-015 SHALL have port resp_err, output, 1, request rejected with no memory write.
REQ-016 SHALL have port mem_addr, output, MEM_AW, word index equal to req_addr[31:2] zero-extended.
REQ-017 SHALL have port mem_wdata, output, 32, write word.
REQ-018 SHALL have port mem_we, output, 1, write enable, sampled by the memory on the CLK rising edge.
REQ-019 SHALL have port mem_rdata, input, 32, combinational read data for mem_addr.

Function
REQ-020 SHALL implement an FSM with states IDLE, LOAD, STORE_W, RMW_RD, RMW_WR, RESP.
REQ-021 SHALL drive req_ready=1 only in IDLE; an accepted request SHALL latch addr/size/we/unsigned/wdata.
REQ-022 SHALL handle accepted requests as follows: load -> LOAD; word store -> STORE_W; byte/half store -> RMW_RD; error -> RESP with resp_err=1 and no memory cycle.
REQ-023 In LOAD, SHALL capture mem_rdata, select the byte at addr[1:0] or the half at addr[1], extend it per req_unsigned, and go to RESP.
REQ-024 In STORE_W, SHALL assert mem_we for one cycle with mem_wdata=wdata, then go to RESP.
REQ-025 In RMW_RD, SHALL capture mem_rdata and merge wdata[7:0] or wdata[15:0] into the addressed lane; in RMW_WR, SHALL assert mem_we with the merged word, then go to RESP.
REQ-026 SHALL hold resp_valid=1 only in RESP, with data and err stable until resp_ready, then return to IDLE; back-to-back acceptance SHALL start no earlier than the cycle after the RESP handshake.
REQ-027 SHALL meet these latencies from the acceptance edge to resp_valid: load 2 cycles, word store 2 cycles, sub-word store 3 cycles, error 1 cycle.
REQ-028 SHALL reject req_size=11 with resp_err=1.
REQ-029 SHALL reject a word index >= MEM_WORDS with resp_err=1, regardless of configuration.
REQ-030 SHALL assert mem_we only in STORE_W and RMW_WR; mem_addr SHALL hold the latched word index in all non-IDLE states.

Reset
REQ-031 On RST low, the FSM SHALL go to IDLE immediately, with req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, mem_addr=0, mem_wdata=0, and all latched registers cleared.
REQ-032 A reset during RMW_RD, RMW_WR or RESP SHALL abandon the request with no write and no response.

Configuration
REQ-033 With LSU_MISALIGN_CHECK_EN defined, a half at odd addr or a word with addr[1:0]!=0 SHALL give resp_err=1; undefined, the low address bits below the access size SHALL be ignored (forced aligned) and no misalignment error SHALL be raised.

Structure
REQ-034 Package lsu_pkg SHALL hold the size encodings SZ_B/SZ_H/SZ_W, the FSM state enum, and the lane-select helper constants.
REQ-035 Combinational lane extract/extend and merge logic SHALL be placed in sub-module lsu_align; the FSM and registers SHALL be in lsu_ctrl.

Verification
REQ-036 Memory word 5=0x8899AABB, load byte signed at addr 0x15 -> resp_rdata=0xFFFFFFAA at acceptance+2.
REQ-037 Store half 0x1234 at addr 0x16 onto word 0x8899AABB -> exactly one mem_we pulse at word 5 with mem_wdata=0x1234AABB, response at acceptance+3.
REQ-038 With LSU_MISALIGN_CHECK_EN defined, a word store at 0x13 -> resp_err=1 at acceptance+1 and no mem_we; without the macro -> write to word 4.
REQ-039 Load at word index 101 -> resp_err=1, no mem_we; resp_ready held low 3 cycles -> resp_valid and resp_err held stable, req_ready=0.
REQ-040 Assert RST in RMW_RD -> mem_we never asserted, memory word unchanged, req_ready=1 after the reset edge.
